multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; the 4-bit state encoding in REQ-017 is fixed.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have these ports, one per line:
  clk  in  1  rising-edge clock
  reset  in  1  async active-high reset
  opcode  in  7  IR[6:0] from the instruction register
  funct3  in  3  IR[14:12]
  zero  in  1  ALU zero flag, combinational
  mem_ready  in  1  memory completes the current access at this edge
  pc_write  out  1  PC load enable
  ir_write  out  1  IR/old-PC load enable
  mem_read  out  1  memory read request (fetch or load)
  mem_write  out  1  memory write request
  reg_write  out  1  register-file write enable
  alu_src_a  out  2  00 PC, 01 old PC, 10 rs1
  alu_src_b  out  2  00 rs2, 01 constant 4, 10 imm_gen output
  alu_op  out  2  00 add, 01 sub/compare, 10 decode funct fields
  pc_src  out  2  00 ALU result, 01 ALUOut register
  wb_sel  out  2  00 ALUOut, 01 memory data, 10 PC (PC+4)
  illegal  out  1  sticky illegal-instruction flag
  state  out  4  current state, debug

Function
REQ-004 The block SHALL be a Moore FSM; outputs are decoded from state, except the gating by mem_ready, zero and funct3 stated below.
REQ-005 Outputs not listed for a state SHALL be 0.
REQ-006 FETCH: mem_read=1, a=00, b=01, op=00, pc_src=00; pc_write and ir_write SHALL equal mem_ready; stay while !mem_ready, else go to DECODE.
REQ-007 DECODE: a=01, b=10, op=00 (branch/jal target into ALUOut); next state by opcode: 0110011 EXEC_R, 0010011 EXEC_I, 0000011/0100011 MEM_ADDR, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, anything else ILLEGAL.
REQ-008 MEM_ADDR: a=10, b=10, op=00; go to MEM_RD on a load, else MEM_WR.
REQ-009 MEM_RD: mem_read=1; hold until mem_ready, then go to MEM_WB. MEM_WB: reg_write=1, wb_sel=01, then FETCH.
REQ-010 MEM_WR: mem_write=1; hold until mem_ready, then go to FETCH.
REQ-011 EXEC_R: a=10, b=00, op=10. EXEC_I: a=10, b=10, op=10. Both go to ALU_WB. ALU_WB: reg_write=1, wb_sel=00, then FETCH.
REQ-012 BRANCH: a=10, b=00, op=01, pc_src=01; pc_write=(funct3==000 & zero)|(funct3==001 & !zero); any other funct3 is treated as not-taken; then FETCH.
REQ-013 ILLEGAL: illegal=1 and all enables 0; the block stays in ILLEGAL until reset.
REQ-014 The block SHALL sample mem_ready only in FETCH, MEM_RD and MEM_WR and ignore it in all other states.
REQ-015 Instruction latency with zero memory wait SHALL be: R/I/JAL/JALR/branch 4 or 3 cycles as walked; load 5; store 4. Each mem_ready-low cycle adds one cycle.
REQ-016 A request output (mem_read/mem_write) SHALL stay constant from first assertion until the edge at which mem_ready is sampled high.
REQ-017 The state encoding SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, JALR 11, ILLEGAL 15; codes 12-14 SHALL go to ILLEGAL.

Reset
REQ-018 Asserting reset SHALL immediately (asynchronously) set state to 0 and drive every output, including illegal, to 0 while reset is high.
REQ-019 Reset mid-access SHALL abandon the access without completing it; the first cycle after release SHALL be FETCH with mem_read=1.

Configuration
REQ-020 Macro CTRL_JUMP_EN: when defined, JAL and JALR are implemented. JAL: pc_src=01, pc_write=1, reg_write=1, wb_sel=10. JALR: a=10, b=10, op=00, pc_src=00, pc_write=1, reg_write=1, wb_sel=10. Both go to FETCH.
REQ-021 When CTRL_JUMP_EN is undefined, opcodes 1101111 and 1100111 SHALL go to ILLEGAL, and codes 10/11 SHALL behave as unused codes.

Verification
REQ-022 Reset, then R-type 0110011 with mem_ready=1 -> state 0,1,6,8,0; reg_write=1 only in state 8.
REQ-023 Load 0000011 with mem_ready low 3 cycles in MEM_RD -> mem_read high 4 cycles in state 3, then state 4 with reg_write=1 and wb_sel=01.
REQ-024 BRANCH with funct3=000, zero=1 -> pc_write=1, pc_src=01; zero=0 -> pc_write=0; funct3=001, zero=0 -> pc_write=1.
REQ-025 Opcode 1111111 -> state 15, illegal=1 held for 10+ cycles regardless of inputs, cleared only by reset.
REQ-026 Reset asserted mid-MEM_WR (mem_write=1) -> mem_write=0 in the same cycle; after release state=0 with mem_read=1.
REQ-027 Opcode 1101111: with CTRL_JUMP_EN -> states 0,1,10,0 with pc_write=1, reg_write=1, wb_sel=10 in state 10; without it -> state 15.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle RV32 datapath; CTRL_JUMP_EN enables JAL/JALR.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
    MEM_WR = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7, ALU_WB = 4'd8, BRANCH = 4'd9,
    JAL = 4'd10, JALR = 4'd11, ILLEGAL = 4'd15
  } state_t;
  state_t cur, nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  assign state = cur;
  always_comb begin
    nxt = ILLEGAL;
    pc_write = 1'b0;
    ir_write = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_src = 2'b00;
    wb_sel = 2'b00;
    illegal = 1'b0;
    case (cur)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        pc_write = mem_ready;
        ir_write = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        nxt = opcode == 7'b0110011 ? EXEC_R :
              opcode == 7'b0010011 ? EXEC_I :
              (opcode == 7'b0000011 || opcode == 7'b0100011) ? MEM_ADDR :
              opcode == 7'b1100011 ? BRANCH :
`ifdef CTRL_JUMP_EN
              opcode == 7'b1101111 ? JAL :
              opcode == 7'b1100111 ? JALR :
`endif
              ILLEGAL;
      end
      MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        nxt = opcode == 7'b0000011 ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        nxt = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        wb_sel = 2'b01;
        nxt = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        nxt = mem_ready ? FETCH : MEM_WR;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op = 2'b10;
        nxt = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op = 2'b10;
        nxt = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op = 2'b01;
        pc_src = 2'b01;
        pc_write = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
        nxt = FETCH;
      end
`ifdef CTRL_JUMP_EN
      JAL: begin
        pc_src = 2'b01;
        pc_write = 1'b1;
        reg_write = 1'b1;
        wb_sel = 2'b10;
        nxt = FETCH;
      end
      JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        pc_write = 1'b1;
        reg_write = 1'b1;
        wb_sel = 2'b10;
        nxt = FETCH;
      end
`else
      JAL, JALR: nxt = ILLEGAL;
`endif
      ILLEGAL: begin
        illegal = 1'b1;
        nxt = ILLEGAL;
      end
      default: nxt = ILLEGAL;
    endcase
    // FETCH decodes mem_read=1, so reset must mask the outputs, not just the state
    if (reset) begin
      pc_write = 1'b0;
      ir_write = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      alu_src_a = 2'b00;
      alu_src_b = 2'b00;
      alu_op = 2'b00;
      pc_src = 2'b00;
      wb_sel = 2'b00;
      illegal = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; stimulus queues hand-computed output vectors, a negedge monitor checks them.
module tb_multicycle_ctrl;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic pc_write, ir_write, mem_read, mem_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src, wb_sel;
  logic [3:0] state;
  int n_checks = 0, n_fail = 0;
  typedef struct { logic [19:0] e; string n; } exp_t;
  exp_t q[$];
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_BAD = 7'b1111111;
  // {state, pc_write, ir_write, mem_read, mem_write, reg_write, a, b, op, pc_src, wb_sel, illegal}
  localparam logic [19:0] Z = 20'h00000, F1 = 20'h0E080, F0 = 20'h02080, DEC = 20'h10300,
    EXR = 20'h60440, EXI = 20'h70540, AWB = 20'h80800, MAD = 20'h20500, MRD = 20'h32000,
    MWB = 20'h40802, MWR = 20'h51000, BRT = 20'h98428, BRN = 20'h90428, ILL = 20'hF0001,
    JALV = 20'hA880C, JALRV = 20'hB8D04;
  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .wb_sel(wb_sel), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [6:0] o, input logic [2:0] f, input logic z, input logic mr,
                      input logic rs, input logic [19:0] e, input string n);
    opcode = o;
    funct3 = f;
    zero = z;
    mem_ready = mr;
    reset = rs;
    q.push_back('{e: e, n: n});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t x;
      logic [19:0] got;
      x = q.pop_front();
      got = {state, pc_write, ir_write, mem_read, mem_write, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_src, wb_sel, illegal};
      n_checks++;
      if (got !== x.e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", x.n, got, x.e);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    @(posedge clk);
    #1;
    step(OP_R, 3'd0, 1'b0, 1'b1, 1'b1, Z, "reset0");
    step(OP_R, 3'd0, 1'b0, 1'b1, 1'b1, Z, "reset1");
    step(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, F1, "r_fetch");
    step(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, DEC, "r_decode");
    step(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, EXR, "r_exec");
    step(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, AWB, "r_wb");
    step(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, F1, "i_fetch");
    step(OP_I, 3'd0, 1'b0, 1'b1, 1'b0, DEC, "i_decode");
    step(OP_I, 3'd0, 1'b0, 1'b0, 1'b0, EXI, "i_exec");
    step(OP_I, 3'd0, 1'b0, 1'b0, 1'b0, AWB, "i_wb");
    step(OP_LD, 3'd0, 1'b0, 1'b1, 1'b0, F1, "ld_fetch");
    step(OP_LD, 3'd0, 1'b0, 1'b0, 1'b0, DEC, "ld_decode_ign_ready");
    step(OP_LD, 3'd0, 1'b0, 1'b0, 1'b0, MAD, "ld_addr");
    for (int i = 0; i < 3; i++) step(OP_LD, 3'd0, 1'b0, 1'b0, 1'b0, MRD, "ld_wait");
    step(OP_LD, 3'd0, 1'b0, 1'b1, 1'b0, MRD, "ld_done");
    step(OP_LD, 3'd0, 1'b0, 1'b0, 1'b0, MWB, "ld_wb");
    step(OP_ST, 3'd0, 1'b0, 1'b0, 1'b0, F0, "st_fetch_wait");
    step(OP_ST, 3'd0, 1'b0, 1'b1, 1'b0, F1, "st_fetch");
    step(OP_ST, 3'd0, 1'b0, 1'b1, 1'b0, DEC, "st_decode");
    step(OP_ST, 3'd0, 1'b0, 1'b1, 1'b0, MAD, "st_addr");
    step(OP_ST, 3'd0, 1'b0, 1'b0, 1'b0, MWR, "st_wait");
    step(OP_ST, 3'd0, 1'b0, 1'b1, 1'b0, MWR, "st_done");
    step(OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, F1, "beq_fetch");
    step(OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, DEC, "beq_decode");
    step(OP_BR, 3'd0, 1'b1, 1'b1, 1'b0, BRT, "beq_taken");
    step(OP_BR, 3'd0, 1'b0, 1'b1, 1'b0, F1, "beq_fetch2");
    step(OP_BR, 3'd0, 1'b0, 1'b1, 1'b0, DEC, "beq_decode2");
    step(OP_BR, 3'd0, 1'b0, 1'b1, 1'b0, BRN, "beq_not_taken");
    step(OP_BR, 3'd1, 1'b0, 1'b1, 1'b0, F1, "bne_fetch");
    step(OP_BR, 3'd1, 1'b0, 1'b1, 1'b0, DEC, "bne_decode");
    step(OP_BR, 3'd1, 1'b0, 1'b1, 1'b0, BRT, "bne_taken");
    step(OP_BR, 3'd1, 1'b1, 1'b1, 1'b0, F1, "bne_fetch2");
    step(OP_BR, 3'd1, 1'b1, 1'b1, 1'b0, DEC, "bne_decode2");
    step(OP_BR, 3'd1, 1'b1, 1'b1, 1'b0, BRN, "bne_not_taken");
    step(OP_BR, 3'd2, 1'b1, 1'b1, 1'b0, F1, "b010_fetch");
    step(OP_BR, 3'd2, 1'b1, 1'b1, 1'b0, DEC, "b010_decode");
    step(OP_BR, 3'd2, 1'b1, 1'b1, 1'b0, BRN, "b010_not_taken");
    step(OP_ST, 3'd0, 1'b0, 1'b1, 1'b0, F1, "rst_st_fetch");
    step(OP_ST, 3'd0, 1'b0, 1'b1, 1'b0, DEC, "rst_st_decode");
    step(OP_ST, 3'd0, 1'b0, 1'b1, 1'b0, MAD, "rst_st_addr");
    step(OP_ST, 3'd0, 1'b0, 1'b0, 1'b0, MWR, "rst_st_wait");
    step(OP_ST, 3'd0, 1'b0, 1'b0, 1'b1, Z, "rst_mid_write");
    step(OP_ST, 3'd0, 1'b0, 1'b0, 1'b0, F0, "rst_release_fetch");
    step(OP_JAL, 3'd0, 1'b0, 1'b1, 1'b0, F1, "jal_fetch");
    step(OP_JAL, 3'd0, 1'b0, 1'b1, 1'b0, DEC, "jal_decode");
`ifdef CTRL_JUMP_EN
    step(OP_JAL, 3'd0, 1'b0, 1'b1, 1'b0, JALV, "jal_exec");
    step(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b0, F1, "jalr_fetch");
    step(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b0, DEC, "jalr_decode");
    step(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b0, JALRV, "jalr_exec");
    step(OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, F1, "bad_fetch");
`else
    step(OP_JAL, 3'd0, 1'b0, 1'b1, 1'b0, ILL, "jal_illegal");
    step(OP_JAL, 3'd0, 1'b0, 1'b1, 1'b1, Z, "jal_reset");
    step(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b0, F1, "jalr_fetch");
    step(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b0, DEC, "jalr_decode");
    step(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b0, ILL, "jalr_illegal");
    step(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b1, Z, "jalr_reset");
    step(OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, F1, "bad_fetch");
`endif
    step(OP_BAD, 3'd0, 1'b0, 1'b1, 1'b0, DEC, "bad_decode");
    for (int i = 0; i < 12; i++)
      step(i[0] ? OP_R : OP_LD, i[2:0], i[1], i[0], 1'b0, ILL, "illegal_hold");
    step(OP_R, 3'd0, 1'b0, 1'b1, 1'b1, Z, "illegal_reset");
    step(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, F1, "illegal_release");
    repeat (3) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
